// File: rtl/game_state_ctrl.sv
// Purpose : top-level snake game FSM (INIT/BASIC/INV/RESPAWN/DEAD/WIN[/PAUSE]) with
//           invincibility countdown, life counter and win-length compare.
// Latency : 1 cycle, inputs sampled on clk and every output registered; no backpressure.
// Ports   : clk, reset (sync, active-high), start, tick, snake_len, touch_edge/poison/
//           self/barrier/ifruit (valid with tick), pause_req (GAME_PAUSE_EN only) ->
//           state, inv_left, lives_left, life_lost, game_over.
// Config  : define GAME_PAUSE_EN to add the pause_req port and the PAUSE state (6).
//           Without it, pause_req is absent and encoding 6 is treated as unused.
module game_state_ctrl #(
    parameter int LEN_W         = 6,
    parameter int WIN_LEN       = 20,
    parameter int INV_TICKS     = 5,
    parameter int RESPAWN_TICKS = 2,
    parameter int LIVES         = 3,
    parameter int CNT_W         = 4,
    parameter int LIFE_W        = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              tick,
    input  logic [LEN_W-1:0]  snake_len,
    input  logic              touch_edge,
    input  logic              touch_poison,
    input  logic              touch_self,
    input  logic              touch_barrier,
    input  logic              touch_ifruit,
`ifdef GAME_PAUSE_EN
    input  logic              pause_req,
`endif
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  inv_left,
    output logic [LIFE_W-1:0] lives_left,
    output logic              life_lost,
    output logic              game_over
);

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_BASIC   = 3'd1;
    localparam logic [2:0] S_INV     = 3'd2;
    localparam logic [2:0] S_DEAD    = 3'd3;
    localparam logic [2:0] S_WIN     = 3'd4;
    localparam logic [2:0] S_RESPAWN = 3'd5;
`ifdef GAME_PAUSE_EN
    localparam logic [2:0] S_PAUSE   = 3'd6;
`endif

    localparam logic [LEN_W-1:0]  WIN_L  = LEN_W'(WIN_LEN);
    localparam logic [CNT_W-1:0]  INV_L  = CNT_W'(INV_TICKS);
    localparam logic [CNT_W-1:0]  RESP_L = CNT_W'(RESPAWN_TICKS);
    localparam logic [LIFE_W-1:0] LIVE_L = LIFE_W'(LIVES);

    logic [CNT_W-1:0]  resp_cnt;
    logic [2:0]        state_n;
    logic [CNT_W-1:0]  inv_n;
    logic [CNT_W-1:0]  resp_n;
    logic [LIFE_W-1:0] lives_n;
    logic              lost_n;
    logic              do_lose;
    logic              fatal_b;
    logic              fatal_i;
    logic              win;
`ifdef GAME_PAUSE_EN
    logic [2:0]        saved_state;
    logic [2:0]        saved_n;
`endif

    // Poison only hurts while vulnerable; win is checked on every cycle.
    assign fatal_b = touch_edge | touch_poison | touch_self | touch_barrier;
    assign fatal_i = touch_edge | touch_self | touch_barrier;
    assign win     = (snake_len >= WIN_L);

    always_comb begin
        state_n = state;
        inv_n   = inv_left;
        resp_n  = resp_cnt;
        lives_n = lives_left;
        lost_n  = 1'b0;
        do_lose = 1'b0;
`ifdef GAME_PAUSE_EN
        saved_n = saved_state;
`endif
        case (state)
            S_INIT: begin
                inv_n = '0;
                if (start) begin
                    state_n = S_BASIC;
                    lives_n = LIVE_L;
                end
            end
            S_BASIC: begin
                inv_n = '0;
                if (tick && fatal_b) begin
                    do_lose = 1'b1;
                end else if (win) begin
                    state_n = S_WIN;
                end else if (tick && touch_ifruit) begin
                    state_n = S_INV;
                    inv_n   = INV_L;
                end
            end
            S_INV: begin
                if (tick && fatal_i) begin
                    do_lose = 1'b1;
                end else if (win) begin
                    state_n = S_WIN;
                    inv_n   = '0;
                end else if (tick && touch_ifruit) begin
                    inv_n = INV_L;
                end else if (tick) begin
                    // Saturating countdown; reaching zero ends invincibility.
                    if (inv_left <= CNT_W'(1)) begin
                        inv_n   = '0;
                        state_n = S_BASIC;
                    end else begin
                        inv_n = inv_left - CNT_W'(1);
                    end
                end
            end
            S_RESPAWN: begin
                inv_n = '0;
                if (tick) begin
                    if (resp_cnt <= CNT_W'(1)) begin
                        resp_n  = '0;
                        state_n = S_BASIC;
                    end else begin
                        resp_n = resp_cnt - CNT_W'(1);
                    end
                end
            end
            S_DEAD, S_WIN: begin
                inv_n = '0;
                if (start) begin
                    state_n = S_INIT;
                end
            end
`ifdef GAME_PAUSE_EN
            S_PAUSE: begin
                // Everything frozen; only the resume toggle matters.
                if (pause_req) begin
                    state_n = saved_state;
                end
            end
`endif
            default: begin
                state_n = S_INIT;
                inv_n   = '0;
            end
        endcase

        if (do_lose) begin
            inv_n  = '0;
            lost_n = 1'b1;
            if (lives_left > LIFE_W'(1)) begin
                lives_n = lives_left - LIFE_W'(1);
                resp_n  = RESP_L;
                state_n = S_RESPAWN;
            end else begin
                lives_n = '0;
                state_n = S_DEAD;
            end
        end

`ifdef GAME_PAUSE_EN
        // Pause overrides any same-cycle event and keeps all counters as they are.
        if (pause_req && (state == S_BASIC || state == S_INV || state == S_RESPAWN)) begin
            state_n = S_PAUSE;
            saved_n = state;
            inv_n   = inv_left;
            resp_n  = resp_cnt;
            lives_n = lives_left;
            lost_n  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_INIT;
            inv_left   <= '0;
            resp_cnt   <= '0;
            lives_left <= LIVE_L;
            life_lost  <= 1'b0;
            game_over  <= 1'b0;
`ifdef GAME_PAUSE_EN
            saved_state <= S_INIT;
`endif
        end else begin
            state      <= state_n;
            inv_left   <= inv_n;
            resp_cnt   <= resp_n;
            lives_left <= lives_n;
            life_lost  <= lost_n;
            game_over  <= (state_n == S_DEAD) || (state_n == S_WIN);
`ifdef GAME_PAUSE_EN
            saved_state <= saved_n;
`endif
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Purpose : directed self-checking bench for game_state_ctrl with default parameters.
// Latency : each step drives inputs after a rising edge and checks one edge later.
// Pause steps are built only when GAME_PAUSE_EN is defined.
module tb_game_state_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, tick;
    logic [5:0] snake_len;
    logic       touch_edge, touch_poison, touch_self, touch_barrier, touch_ifruit;
`ifdef GAME_PAUSE_EN
    logic       pause_req;
`endif
    logic [2:0] state;
    logic [3:0] inv_left;
    logic [1:0] lives_left;
    logic       life_lost, game_over;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_state_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .tick(tick), .snake_len(snake_len),
        .touch_edge(touch_edge), .touch_poison(touch_poison), .touch_self(touch_self),
        .touch_barrier(touch_barrier), .touch_ifruit(touch_ifruit),
`ifdef GAME_PAUSE_EN
        .pause_req(pause_req),
`endif
        .state(state), .inv_left(inv_left), .lives_left(lives_left),
        .life_lost(life_lost), .game_over(game_over)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One game tick with the given collision flags {edge,poison,self,barrier,ifruit}.
    task automatic do_tick(input logic [4:0] f);
        tick = 1'b1;
        {touch_edge, touch_poison, touch_self, touch_barrier, touch_ifruit} = f;
        cyc();
        tick = 1'b0;
        {touch_edge, touch_poison, touch_self, touch_barrier, touch_ifruit} = 5'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    localparam logic [4:0] F_NONE   = 5'b00000;
    localparam logic [4:0] F_EDGE   = 5'b10000;
    localparam logic [4:0] F_POISON = 5'b01000;
    localparam logic [4:0] F_SELF   = 5'b00100;
    localparam logic [4:0] F_BARR   = 5'b00010;
    localparam logic [4:0] F_FRUIT  = 5'b00001;

    initial begin
        reset = 1'b1; start = 1'b0; tick = 1'b0; snake_len = 6'd5;
        {touch_edge, touch_poison, touch_self, touch_barrier, touch_ifruit} = 5'b0;
`ifdef GAME_PAUSE_EN
        pause_req = 1'b0;
`endif
        cyc(); cyc();
        reset = 1'b0;
        // 1: reset state, then start
        chk("rst_state", 32'(state), 0);
        chk("rst_inv", 32'(inv_left), 0);
        chk("rst_lives", 32'(lives_left), 3);
        chk("rst_lost", 32'(life_lost), 0);
        chk("rst_over", 32'(game_over), 0);
        cyc();
        chk("init_hold", 32'(state), 0);
        pulse_start();
        chk("start_basic", 32'(state), 1);
        chk("start_lives", 32'(lives_left), 3);
        chk("start_inv", 32'(inv_left), 0);

        // 2: invincibility countdown and refresh
        do_tick(F_FRUIT);
        chk("fruit_state", 32'(state), 2);
        chk("fruit_inv", 32'(inv_left), 5);
        cyc();
        chk("notick_inv", 32'(inv_left), 5);
        for (int i = 4; i >= 1; i--) begin
            do_tick(F_NONE);
            chk("count_inv", 32'(inv_left), 32'(i));
            chk("count_state", 32'(state), 2);
        end
        do_tick(F_NONE);
        chk("expire_state", 32'(state), 1);
        chk("expire_inv", 32'(inv_left), 0);
        do_tick(F_FRUIT);
        do_tick(F_NONE); do_tick(F_NONE); do_tick(F_NONE);
        chk("pre_refresh_inv", 32'(inv_left), 2);
        do_tick(F_FRUIT);
        chk("refresh_inv", 32'(inv_left), 5);
        chk("refresh_state", 32'(state), 2);

        // 3: poison harmless in INV, edge costs a life
        do_tick(F_POISON);
        chk("poison_state", 32'(state), 2);
        chk("poison_inv", 32'(inv_left), 4);
        do_tick(F_EDGE);
        chk("inv_hit_state", 32'(state), 5);
        chk("inv_hit_lives", 32'(lives_left), 2);
        chk("inv_hit_lost", 32'(life_lost), 1);
        chk("inv_hit_inv", 32'(inv_left), 0);
        cyc();
        chk("lost_pulse_end", 32'(life_lost), 0);
        chk("resp_hold", 32'(state), 5);
        do_tick(F_EDGE);
        chk("resp_tick1", 32'(state), 5);
        chk("resp_ignore", 32'(lives_left), 2);
        do_tick(F_NONE);
        chk("resp_done", 32'(state), 1);

        // 4: run out of lives from a fresh game
        reset = 1'b1; cyc(); reset = 1'b0;
        pulse_start();
        do_tick(F_BARR);
        chk("l1_lives", 32'(lives_left), 2);
        do_tick(F_NONE); do_tick(F_NONE);
        chk("l1_basic", 32'(state), 1);
        do_tick(F_POISON);
        chk("l2_lives", 32'(lives_left), 1);
        chk("l2_state", 32'(state), 5);
        do_tick(F_NONE); do_tick(F_NONE);
        do_tick(F_SELF);
        chk("l3_lives", 32'(lives_left), 0);
        chk("l3_state", 32'(state), 3);
        chk("l3_over", 32'(game_over), 1);
        chk("l3_lost", 32'(life_lost), 1);
        do_tick(F_EDGE);
        chk("dead_hold", 32'(state), 3);
        chk("dead_lives", 32'(lives_left), 0);
        chk("dead_lost", 32'(life_lost), 0);
        start = 1'b1;
        cyc();
        chk("dead_init", 32'(state), 0);
        chk("dead_over_clr", 32'(game_over), 0);
        cyc();
        start = 1'b0;
        chk("restart_state", 32'(state), 1);
        chk("restart_lives", 32'(lives_left), 3);

        // 5: fatal beats win, win alone, reset mid-INV
        snake_len = 6'd20;
        do_tick(F_SELF);
        snake_len = 6'd5;
        chk("fatal_win_state", 32'(state), 5);
        chk("fatal_win_lives", 32'(lives_left), 2);
        do_tick(F_NONE); do_tick(F_NONE);
        chk("back_basic", 32'(state), 1);
        snake_len = 6'd20;
        cyc();
        snake_len = 6'd5;
        chk("win_state", 32'(state), 4);
        chk("win_over", 32'(game_over), 1);
        pulse_start();
        chk("win_init", 32'(state), 0);
        pulse_start();
        do_tick(F_FRUIT);
        do_tick(F_NONE); do_tick(F_NONE);
        chk("mid_inv", 32'(inv_left), 3);
        reset = 1'b1; start = 1'b1; tick = 1'b1; touch_edge = 1'b1;
        cyc();
        reset = 1'b0; start = 1'b0; tick = 1'b0; touch_edge = 1'b0;
        chk("rst_inv_state", 32'(state), 0);
        chk("rst_inv_inv", 32'(inv_left), 0);
        chk("rst_inv_lives", 32'(lives_left), 3);

`ifdef GAME_PAUSE_EN
        // 6: pause freezes INV
        pulse_start();
        do_tick(F_FRUIT);
        do_tick(F_NONE); do_tick(F_NONE);
        pause_req = 1'b1; cyc(); pause_req = 1'b0;
        chk("pause_state", 32'(state), 6);
        for (int i = 0; i < 10; i++) do_tick(F_EDGE);
        chk("pause_hold", 32'(state), 6);
        chk("pause_lives", 32'(lives_left), 3);
        pause_req = 1'b1; cyc(); pause_req = 1'b0;
        chk("resume_state", 32'(state), 2);
        chk("resume_inv", 32'(inv_left), 3);
        do_tick(F_NONE);
        chk("resume_count", 32'(inv_left), 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
